// File: rtl/shift_sequencer.sv
// Sequenced shifter: one request at a time; result after 1 + ceil(n/STEP) cycles (1 for PASS or n==0).
// in_ready only in IDLE; a result waiting in DONE stalls the unit until out_ready.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AMT_W = 5,
  parameter int SW_W  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW_W-1:0]  in_src_w,
  input  logic             in_src_signed,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_SHL  = 2'b00;
  localparam logic [1:0] OP_SAR  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             fill_q, fill_d;

  int               s_eff;
  int               n_eff;
  int               k;
  logic             sign_bit;
  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] shifted;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_q;

  // Width conversion of the incoming operand and clamping of the amount.
  always_comb begin
    s_eff = WIDTH;
    if (in_src_w != '0 && 32'(in_src_w) <= WIDTH) s_eff = 32'(in_src_w);
    sign_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == s_eff - 1) sign_bit = in_data[i];
    end
    ext = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ext[i] = (i < s_eff) ? in_data[i] : (in_src_signed & sign_bit);
    end
    n_eff = (32'(in_amt) > WIDTH) ? WIDTH : 32'(in_amt);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fill_d  = fill_q;

    k = (32'(cnt_q) < STEP) ? 32'(cnt_q) : STEP;
    if (op_q == OP_SHL) shifted = acc_q << k;
    else                shifted = (acc_q >> k) | (fill_q ? ~(ONES >> k) : '0);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          acc_d  = ext;
          cnt_d  = CNT_W'(n_eff);
          op_d   = in_op;
          fill_d = (in_op == OP_SAR) && in_src_signed && ext[WIDTH-1];
          if (in_op == OP_PASS || n_eff == 0) begin
            out_d   = ext;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - CNT_W'(k);
        if (32'(cnt_q) == k) begin
          out_d   = shifted;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SHL;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: STEP=1 and STEP=4 instances at WIDTH=6, checked against an arithmetic model.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] in_data = '0;
  logic [3:0] in_src_w = '0;
  logic       in_src_signed = 1'b0;
  logic [1:0] in_op = '0;
  logic [4:0] in_amt = '0;

  logic       v1 = 1'b0, r1 = 1'b0, v4 = 1'b0, r4 = 1'b0;
  logic       in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4;
  logic [5:0] out_data1, out_data4;

  bit         sel4 = 1'b0;
  int         total = 0;
  int         bad = 0;

  logic       cur_in_ready, cur_out_valid, cur_busy;
  logic [5:0] cur_out_data;
  assign cur_in_ready  = sel4 ? in_ready4  : in_ready1;
  assign cur_out_valid = sel4 ? out_valid4 : out_valid1;
  assign cur_busy      = sel4 ? busy4      : busy1;
  assign cur_out_data  = sel4 ? out_data4  : out_data1;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(6), .STEP(1), .AMT_W(5)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(in_ready1), .in_data(in_data),
    .in_src_w(in_src_w), .in_src_signed(in_src_signed), .in_op(in_op), .in_amt(in_amt),
    .out_valid(out_valid1), .out_ready(r1), .out_data(out_data1), .busy(busy1));

  shift_sequencer #(.WIDTH(6), .STEP(4), .AMT_W(5)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(in_ready4), .in_data(in_data),
    .in_src_w(in_src_w), .in_src_signed(in_src_signed), .in_op(in_op), .in_amt(in_amt),
    .out_valid(out_valid4), .out_ready(r4), .out_data(out_data4), .busy(busy4));

  // Reference: operand as a signed/unsigned integer, shifts as integer arithmetic.
  function automatic logic [5:0] model_res(logic [5:0] d, int sw, bit sg, logic [1:0] op, int amt);
    int     s, n;
    longint v, u;
    s = (sw == 0 || sw > 6) ? 6 : sw;
    v = longint'(d) & ((64'sd1 << s) - 1);
    if (sg && v >= (64'sd1 << (s - 1))) v = v - (64'sd1 << s);
    u = v & 63;
    n = (amt > 6) ? 6 : amt;
    case (op)
      2'b00:   v = v * (64'sd1 << n);
      2'b01:   v = u >> n;
      2'b10:   v = sg ? (v >>> n) : (u >> n);
      default: v = v;
    endcase
    return v[5:0];
  endfunction

  function automatic int model_lat(logic [1:0] op, int amt, int step);
    int n;
    n = (amt > 6) ? 6 : amt;
    if (op == 2'b11 || n == 0) return 1;
    return 1 + (n + step - 1) / step;
  endfunction

  task automatic start(logic [5:0] d, int sw, bit sg, logic [1:0] op, int amt);
    @(negedge clk);
    in_data = d; in_src_w = 4'(sw); in_src_signed = sg; in_op = op; in_amt = 5'(amt);
    if (sel4) v4 = 1'b1; else v1 = 1'b1;
    for (int i = 0; i < 50 && !cur_in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    v1 = 1'b0; v4 = 1'b0;
    // Scramble request fields after accept; the unit must have latched them.
    in_data = 6'($urandom); in_src_w = 4'($urandom); in_src_signed = 1'($urandom);
    in_op = 2'($urandom); in_amt = 5'($urandom);
  endtask

  task automatic wait_out(output int lat, output logic [5:0] d);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (cur_out_valid) begin
        lat = c;
        break;
      end
    end
    d = cur_out_data;
  endtask

  task automatic consume();
    @(negedge clk);
    if (sel4) r4 = 1'b1; else r1 = 1'b1;
    @(posedge clk);
    #1;
    r1 = 1'b0; r4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready1 !== 1'b0 || in_ready4 !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready got=%b/%b want=0/0", in_ready1, in_ready4);
    end
    total++;
    if (out_valid1 !== 1'b0 || out_data1 !== 6'd0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL reset_state got v=%b d=%b busy=%b want v=0 d=000000 busy=0", out_valid1, out_data1, busy1);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready1 !== 1'b1) begin
      bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready1);
    end
  endtask

  task automatic test_directed();
    // data, src_w, signed, op, amt, expected result, expected latency
    logic [5:0] dv [7] = '{6'b000100, 6'b000100, 6'b000110, 6'b111100, 6'b000110, 6'b000110, 6'b101101};
    int         sw [7] = '{3, 3, 3, 6, 3, 3, 6};
    bit         sg [7] = '{0, 1, 1, 0, 1, 0, 0};
    logic [1:0] op [7] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
    int         am [7] = '{1, 1, 1, 1, 2, 0, 0};
    logic [5:0] ex [7] = '{6'b001000, 6'b111000, 6'b111111, 6'b011110, 6'b111110, 6'b000110, 6'b101101};
    int         el [7] = '{2, 2, 2, 2, 1, 1, 1};
    int         lat;
    logic [5:0] d;
    sel4 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      start(dv[i], sw[i], sg[i], op[i], am[i]);
      wait_out(lat, d);
      total++;
      if (d !== ex[i] || lat !== el[i]) begin
        bad++; $display("FAIL directed_%0d got d=%b lat=%0d want d=%b lat=%0d", i, d, lat, ex[i], el[i]);
      end
      consume();
    end
  endtask

  task automatic test_saturate();
    int         lat;
    logic [5:0] d;
    sel4 = 1'b0;
    start(6'b100000, 6, 1'b1, 2'b10, 31);
    wait_out(lat, d);
    total++;
    if (d !== 6'b111111 || lat !== 7) begin
      bad++; $display("FAIL sat_sar got d=%b lat=%0d want d=111111 lat=7", d, lat);
    end
    consume();
    start(6'b100000, 6, 1'b1, 2'b00, 31);
    wait_out(lat, d);
    total++;
    if (d !== 6'b000000 || lat !== 7) begin
      bad++; $display("FAIL sat_shl got d=%b lat=%0d want d=000000 lat=7", d, lat);
    end
    consume();
  endtask

  task automatic test_step4();
    int         lat;
    logic [5:0] d;
    sel4 = 1'b1;
    start(6'b111111, 6, 1'b0, 2'b01, 5);
    wait_out(lat, d);
    total++;
    if (d !== 6'b000001 || lat !== 3) begin
      bad++; $display("FAIL step4_shr5 got d=%b lat=%0d want d=000001 lat=3", d, lat);
    end
    consume();
    start(6'b100000, 6, 1'b1, 2'b10, 31);
    wait_out(lat, d);
    total++;
    if (d !== 6'b111111 || lat !== 3) begin
      bad++; $display("FAIL step4_sar31 got d=%b lat=%0d want d=111111 lat=3", d, lat);
    end
    consume();
    sel4 = 1'b0;
  endtask

  task automatic test_backpressure();
    int         lat;
    logic [5:0] d;
    int         drift = 0;
    sel4 = 1'b0;
    start(6'b010011, 6, 1'b0, 2'b00, 1);
    wait_out(lat, d);
    total++;
    if (d !== 6'b100110) begin
      bad++; $display("FAIL bp_result got=%b want=100110", d);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid1 !== 1'b1 || out_data1 !== 6'b100110 || in_ready1 !== 1'b0) drift++;
    end
    total++;
    if (drift !== 0) begin
      bad++; $display("FAIL bp_hold got %0d unstable cycles want 0", drift);
    end
    consume();
    @(negedge clk);
    total++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      bad++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready1, out_valid1);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    sel4 = 1'b0;
    start(6'b000011, 6, 1'b0, 2'b00, 5);
    @(negedge clk);
    total++;
    if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
      bad++; $display("FAIL midrst_shifting got busy=%b v=%b want 1/0", busy1, out_valid1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid1 !== 1'b0 || out_data1 !== 6'd0 || busy1 !== 1'b0 || in_ready1 !== 1'b1) begin
      bad++; $display("FAIL midrst_state got v=%b d=%b busy=%b rdy=%b want 0/000000/0/1",
                      out_valid1, out_data1, busy1, in_ready1);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid1 === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL midrst_no_output got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_random(bit use4, int count);
    int         lat, sw, amt, step, exp_lat;
    bit         sg;
    logic [1:0] op;
    logic [5:0] d, dat, exp_d;
    sel4 = use4;
    step = use4 ? 4 : 1;
    for (int i = 0; i < count; i++) begin
      dat = 6'($urandom);
      sw  = $urandom_range(0, 7);
      sg  = 1'($urandom);
      op  = 2'($urandom);
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(7, 31) : $urandom_range(0, 6);
      exp_d   = model_res(dat, sw, sg, op, amt);
      exp_lat = model_lat(op, amt, step);
      start(dat, sw, sg, op, amt);
      wait_out(lat, d);
      total++;
      if (d !== exp_d || lat !== exp_lat) begin
        bad++; $display("FAIL rand_s%0d_%0d in=%b sw=%0d sg=%0d op=%0d amt=%0d got d=%b lat=%0d want d=%b lat=%0d",
                        step, i, dat, sw, sg, op, amt, d, lat, exp_d, exp_lat);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume();
    end
    sel4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturate();
    test_step4();
    test_backpressure();
    test_reset_mid();
    test_random(1'b0, 60);
    test_random(1'b1, 30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
